// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding
// and the width of the state register.
package serial_adder_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_seq_cell.sv
// 1-bit full-adder cell: gate-level sum and carry from a, b and carry-in.
module adderstructural (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic axb;
  logic ab;
  logic cx;

  assign axb  = a ^ b;
  assign ab   = a & b;
  assign cx   = cin & axb;
  assign s    = axb ^ cin;
  assign cout = ab | cx;

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: accepts operands over valid/ready, feeds one bit
// pair per clock into a full-adder cell LSB first, returns {cout,sum}.
module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;

  logic             cell_s;
  logic             cell_cout;
  logic [WIDTH-1:0] sum_shift;

  adderstructural u_cell (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  // Shift-in from the top expressed with shifts so WIDTH=1 needs no empty slice.
  assign sum_shift = (sum_q >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sh_a_d     = op_a;
          sh_b_d     = op_b;
          carry_d    = in_cin;
          cnt_d      = '0;
          sum_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        sum_d   = sum_shift;
        carry_d = cell_cout;
        cnt_d   = cnt_q + 1'b1;
        // Result registers load on the final bit so outputs stay zero until DONE.
        if (cnt_q == CNT_LAST) begin
          res_sum_d   = sum_shift;
          res_cout_d  = cell_cout;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          res_sum_d   = '0;
          res_cout_d  = 1'b0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        res_sum_d   = '0;
        res_cout_d  = 1'b0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = res_sum_q;
  assign cout      = res_cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench for serial_adder_seq at WIDTH=8 plus a WIDTH=1 instance.
module tb_serial_adder_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic       in_cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] sum;
  logic       cout;

  logic       w1_in_valid = 1'b0;
  logic       w1_in_ready;
  logic [0:0] w1_op_a = '0;
  logic [0:0] w1_op_b = '0;
  logic       w1_in_cin = 1'b0;
  logic       w1_out_valid;
  logic       w1_out_ready = 1'b0;
  logic [0:0] w1_sum;
  logic       w1_cout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  serial_adder_seq #(.WIDTH(1)) dut_w1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w1_in_valid),
    .in_ready  (w1_in_ready),
    .op_a      (w1_op_a),
    .op_b      (w1_op_b),
    .in_cin    (w1_in_cin),
    .out_valid (w1_out_valid),
    .out_ready (w1_out_ready),
    .sum       (w1_sum),
    .cout      (w1_cout)
  );

  // Runs one add on the WIDTH=8 instance; returns latency after the accept edge.
  task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat, output logic [7:0] s, output logic co,
                        output bit ok);
    int guard;
    ok = 1'b1;
    op_a = a; op_b = b; in_cin = c; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) ok = 1'b0;
    s = sum; co = cout;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b, want rdy=1 vld=0 sum=00 cout=0",
               in_ready, out_valid, sum, cout);
    end
  endtask

  task automatic test_basic;
    int lat; logic [7:0] s; logic co; bit ok;
    do_add(8'h00, 8'h00, 1'b0, lat, s, co, ok);
    n_checks++;
    if (!ok || lat !== 8) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d (ok=%0d), want 8", lat, ok);
    end
    n_checks++;
    if ({co, s} !== 9'h000) begin
      n_fail++;
      $display("FAIL basic_sum: got %h, want 000", {co, s});
    end
  endtask

  task automatic test_carry;
    logic [7:0] ta [3] = '{8'hFF, 8'hFF, 8'hA5};
    logic [7:0] tb [3] = '{8'h01, 8'hFF, 8'h3C};
    logic       tc [3] = '{1'b0, 1'b1, 1'b1};
    logic [8:0] te [3] = '{9'h100, 9'h1FF, 9'h0E2};
    int lat; logic [7:0] s; logic co; bit ok;
    for (int i = 0; i < 3; i++) begin
      do_add(ta[i], tb[i], tc[i], lat, s, co, ok);
      n_checks++;
      if (!ok || {co, s} !== te[i]) begin
        n_fail++;
        $display("FAIL carry_%0d: got %h (ok=%0d), want %h", i, {co, s}, ok, te[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    op_a = 8'h2D; op_b = 8'h2D; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid = ~in_valid;
      op_a = ~op_a;
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d, want 8", lat);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || sum !== 8'h5A || cout !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got vld=%b sum=%h cout=%b rdy=%b, want vld=1 sum=5a cout=0 rdy=0",
                 i, out_valid, sum, cout, in_ready);
      end
      op_a = ~op_a;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got vld=%b sum=%h cout=%b rdy=%b, want vld=0 sum=00 cout=0 rdy=1",
               out_valid, sum, cout, in_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    op_a = 8'h7F; op_b = 8'h01; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset_state: got rdy=%b vld=%b sum=%h cout=%b, want rdy=1 vld=0 sum=00 cout=0",
               in_ready, out_valid, sum, cout);
    end
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_no_result: got out_valid pulse=%0d, want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pa [200];
    logic [7:0] pb [200];
    logic       pc [200];
    logic [8:0] exp_q [$];
    logic [8:0] e;
    int nxt, got, cyc, last;
    for (int i = 0; i < 200; i++) begin
      pa[i] = 8'($urandom_range(0, 255));
      pb[i] = 8'($urandom_range(0, 255));
      pc[i] = 1'($urandom_range(0, 1));
    end
    nxt = 0; got = 0; cyc = 0; last = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (got < 200 && cyc < 4000) begin
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h000;
        n_checks++;
        if ({cout, sum} !== e) begin
          n_fail++;
          $display("FAIL b2b_result_%0d: got %h, want %h", got, {cout, sum}, e);
        end
        if (got > 0) begin
          n_checks++;
          if (cyc - last !== 10) begin
            n_fail++;
            $display("FAIL b2b_period_%0d: got %0d cycles, want 10", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      if (in_ready && nxt < 200) begin
        op_a = pa[nxt]; op_b = pb[nxt]; in_cin = pc[nxt];
        exp_q.push_back({1'b0, pa[nxt]} + {1'b0, pb[nxt]} + {8'h00, pc[nxt]});
        nxt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (got !== 200) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, want 200", got);
    end
  endtask

  task automatic test_width1;
    logic [1:0] e;
    int lat;
    for (int i = 0; i < 8; i++) begin
      w1_op_a = 1'(i >> 2); w1_op_b = 1'(i >> 1); w1_in_cin = 1'(i);
      e = {1'b0, w1_op_a} + {1'b0, w1_op_b} + {1'b0, w1_in_cin};
      w1_in_valid = 1'b1;
      n_checks++;
      if (w1_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL w1_ready_%0d: got %b, want 1", i, w1_in_ready);
      end
      @(posedge clk); #1;
      w1_in_valid = 1'b0;
      lat = 0;
      while (!w1_out_valid && lat < 10) begin
        @(posedge clk); #1; lat++;
      end
      n_checks++;
      if (lat !== 1 || {w1_cout, w1_sum} !== e) begin
        n_fail++;
        $display("FAIL w1_add_%0d: got lat=%0d res=%b, want lat=1 res=%b", i, lat, {w1_cout, w1_sum}, e);
      end
      w1_out_ready = 1'b1;
      @(posedge clk); #1;
      w1_out_ready = 1'b0;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid_run();
    test_basic();
    test_back_to_back();
    test_width1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
